// File: rtl/dac_spi_multi_ctrl_if.sv
// Register-bus request/ack channel plus the DAC-facing serial pins of dac_spi_multi_ctrl.
// The master side is the requester, and the slave side is the controller.
interface dac_spi_multi_ctrl_if #(
  parameter int NUM_DEV = 2
);
  logic [31:0]        app_din;
  logic               app_req;
  logic               app_ack;
  logic               app_err;
  logic               busy;
  logic [NUM_DEV-1:0] DSYNC_N;
  logic               DCLK;
  logic               DIN;
  logic               DLDAC_N;

  modport master (
    output app_din, app_req,
    input  app_ack, app_err, busy, DSYNC_N, DCLK, DIN, DLDAC_N
  );

  modport slave (
    input  app_din, app_req,
    output app_ack, app_err, busy, DSYNC_N, DCLK, DIN, DLDAC_N
  );
endinterface

// File: rtl/dac_spi_multi_ctrl.sv
// Multi-device serial DAC controller with built-in SPI shifter (CPOL=0/CPHA=1).
// Decodes 32-bit bus writes into per-device, broadcast, mode and LDAC-only operations.
module dac_spi_multi_ctrl #(
  parameter int          NUM_DEV    = 2,
  parameter int          DATA_W     = 16,
  parameter int          CLK_DIV    = 10,
  parameter int          LDAC_PULSE = 3,
  parameter logic [15:0] ADDR_BASE  = 16'hdac0,
  parameter logic [15:0] ADDR_ALL   = 16'hdad0,
  parameter logic [15:0] ADDR_MODE  = 16'hdace,
  parameter logic [15:0] ADDR_LDAC  = 16'hdacf
) (
  input  logic                clk,
  input  logic                rst_n,
  dac_spi_multi_ctrl_if.slave bus
);

  localparam int IDX_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int CNT_MAX = (CLK_DIV > LDAC_PULSE) ? CLK_DIV : LDAC_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LDAC_LD  = CNT_W'(LDAC_PULSE - 1);
  localparam logic [IDX_W-1:0] LAST_DEV = IDX_W'(NUM_DEV - 1);
  localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, DECODE, LOAD, SHIFT, GAP, SYNCHI, LDAC, ACK
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic [IDX_W-1:0]   devIdx_q, devIdx_d;
  logic               bcast_q, bcast_d;
  logic               err_q, err_d;
  logic               autoLdac_q, autoLdac_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
  logic               phaseHi_q, phaseHi_d;

  logic [NUM_DEV-1:0] dsyncN_q, dsyncN_d;
  logic               dclk_q, dclk_d;
  logic               din_q, din_d;
  logic               dldacN_q, dldacN_d;
  logic               ack_q, ack_d;
  logic               errOut_q, errOut_d;
  logic               busy_q, busy_d;

  logic [15:0]        addr;
  logic [15:0]        devOffset;
  logic [DATA_W-1:0]  frame;

  assign addr      = data_q[31:16];
  assign frame     = data_q[DATA_W-1:0];
  assign devOffset = addr - ADDR_BASE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      devIdx_q   <= '0;
      bcast_q    <= 1'b0;
      err_q      <= 1'b0;
      autoLdac_q <= 1'b0;
      cnt_q      <= '0;
      bitCnt_q   <= '0;
      phaseHi_q  <= 1'b0;
      dsyncN_q   <= '1;
      dclk_q     <= 1'b0;
      din_q      <= 1'b0;
      dldacN_q   <= 1'b1;
      ack_q      <= 1'b0;
      errOut_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      devIdx_q   <= devIdx_d;
      bcast_q    <= bcast_d;
      err_q      <= err_d;
      autoLdac_q <= autoLdac_d;
      cnt_q      <= cnt_d;
      bitCnt_q   <= bitCnt_d;
      phaseHi_q  <= phaseHi_d;
      dsyncN_q   <= dsyncN_d;
      dclk_q     <= dclk_d;
      din_q      <= din_d;
      dldacN_q   <= dldacN_d;
      ack_q      <= ack_d;
      errOut_q   <= errOut_d;
      busy_q     <= busy_d;
    end
  end

  // cnt_q times every fixed-length state; it is loaded with length-1 on entry.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    devIdx_d   = devIdx_q;
    bcast_d    = bcast_q;
    err_d      = err_q;
    autoLdac_d = autoLdac_q;
    cnt_d      = cnt_q;
    bitCnt_d   = bitCnt_q;
    phaseHi_d  = phaseHi_q;

    case (state_q)
      IDLE: begin
        if (bus.app_req && !ack_q) begin
          data_d  = bus.app_din;
          bcast_d = 1'b0;
          err_d   = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (addr == ADDR_ALL) begin
          devIdx_d = '0;
          bcast_d  = 1'b1;
          cnt_d    = DIV_LD;
          state_d  = LOAD;
        end else if (addr == ADDR_MODE) begin
          autoLdac_d = data_q[0];
          state_d    = ACK;
        end else if (addr == ADDR_LDAC) begin
          cnt_d   = LDAC_LD;
          state_d = LDAC;
        end else if (devOffset < 16'(NUM_DEV)) begin
          devIdx_d = devOffset[IDX_W-1:0];
          cnt_d    = DIV_LD;
          state_d  = LOAD;
        end else begin
          err_d   = 1'b1;
          state_d = ACK;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          cnt_d     = DIV_LD;
          bitCnt_d  = TOP_BIT;
          phaseHi_d = 1'b1;
          state_d   = SHIFT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = DIV_LD;
          if (phaseHi_q) begin
            phaseHi_d = 1'b0;
          end else if (bitCnt_q == '0) begin
            state_d = GAP;
          end else begin
            bitCnt_d  = bitCnt_q - 1'b1;
            phaseHi_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = DIV_LD;
          state_d = SYNCHI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SYNCHI: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bcast_q && (devIdx_q < LAST_DEV)) begin
          devIdx_d = devIdx_q + 1'b1;
          cnt_d    = DIV_LD;
          state_d  = LOAD;
        end else if (autoLdac_q) begin
          cnt_d   = LDAC_LD;
          state_d = LDAC;
        end else begin
          state_d = ACK;
        end
      end
      LDAC: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so the pins themselves are plain flops.
  always_comb begin
    dsyncN_d = '1;
    if ((state_d == LOAD) || (state_d == SHIFT) || (state_d == GAP)) begin
      dsyncN_d[devIdx_d] = 1'b0;
    end
    dclk_d = (state_d == SHIFT) && phaseHi_d;

    din_d = din_q;
    if ((state_d == LOAD) && (state_q != LOAD)) begin
      din_d = frame[DATA_W-1];
    end else if ((state_d == SHIFT) && phaseHi_d && !((state_q == SHIFT) && phaseHi_q)) begin
      din_d = frame[bitCnt_d];
    end

    dldacN_d = (state_d != LDAC);
    ack_d    = (state_d == ACK);
    errOut_d = (state_d == ACK) && err_d;
    busy_d   = (state_d != IDLE) && (state_d != ACK);
  end

  assign bus.DSYNC_N = dsyncN_q;
  assign bus.DCLK    = dclk_q;
  assign bus.DIN     = din_q;
  assign bus.DLDAC_N = dldacN_q;
  assign bus.app_ack = ack_q;
  assign bus.app_err = errOut_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dac_spi_multi_ctrl.sv
// Directed plus randomized bench for dac_spi_multi_ctrl: a pin monitor rebuilds frames and
// LDAC pulses, and each transaction is compared with a transaction-level model of the decode rules.
module tb_dac_spi_multi_ctrl;

  localparam int          NUM_DEV    = 2;
  localparam int          DATA_W     = 16;
  localparam int          CLK_DIV    = 2;
  localparam int          LDAC_PULSE = 3;
  localparam logic [15:0] ADDR_BASE  = 16'hdac0;
  localparam logic [15:0] ADDR_ALL   = 16'hdad0;
  localparam logic [15:0] ADDR_MODE  = 16'hdace;
  localparam logic [15:0] ADDR_LDAC  = 16'hdacf;
  localparam int          FRAME_LOW  = CLK_DIV * (2 * DATA_W + 2);
  localparam int          BUDGET     = 1000;

  logic clk;
  logic rst_n;

  dac_spi_multi_ctrl_if #(.NUM_DEV(NUM_DEV)) bus ();

  dac_spi_multi_ctrl #(
    .NUM_DEV(NUM_DEV), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LDAC_PULSE(LDAC_PULSE),
    .ADDR_BASE(ADDR_BASE), .ADDR_ALL(ADDR_ALL), .ADDR_MODE(ADDR_MODE), .ADDR_LDAC(ADDR_LDAC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int                dev;
    logic [DATA_W-1:0] data;
    int                lowLen;
    int                pulses;
    bit                hiBad;
    int                firstRise;
    int                start;
    int                stop;
  } frame_t;

  typedef struct {
    int fall;
    int len;
    bit overlap;
  } ldac_t;

  frame_t frQ[$];
  ldac_t  ldQ[$];
  int     ackCycQ[$];
  bit     ackErrQ[$];
  int     busyRiseQ[$];
  int     monErr;

  int                cyc;
  bit                inFrame;
  int                frDev, frStart, frPulses, frFirstRise, hiRun;
  logic [DATA_W-1:0] frData;
  bit                frHiBad;
  bit                prevDclk, prevLdac, prevBusy;
  int                ldFall;
  bit                ldOverlap;

  int checks;
  int failures;
  bit modelAuto;
  bit prevHeld;
  int lastAck;

  // Pin monitor: samples on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    int lowCnt;
    int lowIdx;
    cyc++;
    if (!rst_n) begin
      inFrame  = 1'b0;
      prevDclk = 1'b0;
      prevLdac = 1'b1;
      prevBusy = 1'b0;
    end else begin
      lowCnt = 0;
      lowIdx = 0;
      for (int i = 0; i < NUM_DEV; i++) begin
        if (bus.DSYNC_N[i] !== 1'b1) begin
          lowCnt++;
          lowIdx = i;
        end
      end
      if (lowCnt > 1) monErr++;
      if (!inFrame && lowCnt == 1) begin
        inFrame     = 1'b1;
        frDev       = lowIdx;
        frStart     = cyc;
        frPulses    = 0;
        frData      = '0;
        frHiBad     = 1'b0;
        hiRun       = 0;
        frFirstRise = -1;
      end
      if (inFrame) begin
        if (bus.DCLK && !prevDclk) begin
          frPulses++;
          if (frFirstRise < 0) frFirstRise = cyc - frStart;
        end
        if (bus.DCLK) hiRun = prevDclk ? hiRun + 1 : 1;
        if (!bus.DCLK && prevDclk) begin
          frData = {frData[DATA_W-2:0], bus.DIN};
          if (hiRun != CLK_DIV) frHiBad = 1'b1;
        end
        if (lowCnt == 0) begin
          frQ.push_back('{frDev, frData, cyc - frStart, frPulses, frHiBad, frFirstRise, frStart, cyc});
          inFrame = 1'b0;
        end else if (bus.DSYNC_N[frDev] !== 1'b0) begin
          monErr++;
        end
      end else if (bus.DCLK) begin
        monErr++;
      end
      if (!bus.DLDAC_N) begin
        if (prevLdac) begin
          ldFall    = cyc;
          ldOverlap = 1'b0;
        end
        if (lowCnt != 0) ldOverlap = 1'b1;
      end else if (!prevLdac) begin
        ldQ.push_back('{ldFall, cyc - ldFall, ldOverlap});
      end
      if (bus.app_ack) begin
        ackCycQ.push_back(cyc);
        ackErrQ.push_back(bus.app_err);
      end else if (bus.app_err) begin
        monErr++;
      end
      if (bus.busy && !prevBusy) busyRiseQ.push_back(cyc);
      prevDclk = bus.DCLK;
      prevLdac = bus.DLDAC_N;
      prevBusy = bus.busy;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitor();
    frQ.delete();
    ldQ.delete();
    ackCycQ.delete();
    ackErrQ.delete();
    busyRiseQ.delete();
    monErr = 0;
  endtask

  // Transaction-level reference: what a write of 'word' must produce on the pins.
  task automatic checkTxn(input logic [31:0] word, input bit gotAck);
    logic [15:0] addr;
    int          expFrames, expDev0, expLdac, nFr;
    bit          expErr;
    addr      = word[31:16];
    expFrames = 0;
    expDev0   = 0;
    expLdac   = 0;
    expErr    = 1'b0;
    if (addr == ADDR_ALL) begin
      expFrames = NUM_DEV;
      expLdac   = modelAuto ? 1 : 0;
    end else if (addr == ADDR_MODE) begin
      modelAuto = word[0];
    end else if (addr == ADDR_LDAC) begin
      expLdac = 1;
    end else if (addr >= ADDR_BASE && int'(addr) < int'(ADDR_BASE) + NUM_DEV) begin
      expFrames = 1;
      expDev0   = int'(addr) - int'(ADDR_BASE);
      expLdac   = modelAuto ? 1 : 0;
    end else begin
      expErr = 1'b1;
    end

    checkOutput("ack_seen", gotAck, 1);
    if (!gotAck) begin
      clearMonitor();
      return;
    end
    checkOutput("ack_count", ackCycQ.size(), 1);
    checkOutput("ack_err", ackErrQ[0], expErr);
    checkOutput("busy_rise_count", busyRiseQ.size(), 1);
    if (busyRiseQ.size() > 0) begin
      if (prevHeld) checkOutput("b2b_start_after_ack", busyRiseQ[0] - lastAck, 2);
      if (expErr) checkOutput("err_ack_latency_ok", (ackCycQ[0] - busyRiseQ[0]) <= 3, 1);
    end
    checkOutput("frame_count", frQ.size(), expFrames);
    nFr = (frQ.size() < expFrames) ? frQ.size() : expFrames;
    for (int i = 0; i < nFr; i++) begin
      checkOutput("frame_dev", frQ[i].dev, (expFrames > 1) ? i : expDev0);
      checkOutput("frame_data", frQ[i].data, word[DATA_W-1:0]);
      checkOutput("frame_sync_low", frQ[i].lowLen, FRAME_LOW);
      checkOutput("frame_pulses", frQ[i].pulses, DATA_W);
      checkOutput("frame_dclk_high_len_bad", frQ[i].hiBad, 0);
      checkOutput("frame_first_rise", frQ[i].firstRise, CLK_DIV);
      if (i > 0) checkOutput("frame_gap_ok", (frQ[i].start - frQ[i-1].stop) >= CLK_DIV, 1);
    end
    checkOutput("ldac_count", ldQ.size(), expLdac);
    if (ldQ.size() > 0) begin
      checkOutput("ldac_len", ldQ[0].len, LDAC_PULSE);
      checkOutput("ldac_overlap", ldQ[0].overlap, 0);
      checkOutput("ldac_to_ack", ackCycQ[0] - ldQ[0].fall, LDAC_PULSE);
      if (frQ.size() > 0) checkOutput("synchi_to_ldac", ldQ[0].fall - frQ[frQ.size()-1].stop, CLK_DIV);
    end
    checkOutput("protocol_violations", monErr, 0);
    lastAck = ackCycQ[0];
    clearMonitor();
  endtask

  // Issue one write, scrambling app_din while busy; optionally keep app_req high for the next word.
  task automatic applyStimulus(input logic [31:0] word, input bit hold, input logic [31:0] nextWord);
    bit got;
    bus.app_din = word;
    bus.app_req = 1'b1;
    got = 1'b0;
    for (int n = 0; n < BUDGET && !got; n++) begin
      @(negedge clk);
      #1;
      if (ackCycQ.size() != 0) got = 1'b1;
      else if (bus.busy) bus.app_din = $urandom;
    end
    if (hold) begin
      bus.app_din = nextWord;
    end else begin
      bus.app_req = 1'b0;
      bus.app_din = $urandom;
    end
    checkTxn(word, got);
    prevHeld = hold;
    if (!hold) begin
      @(negedge clk);
      #1;
    end
  endtask

  logic [31:0] words[24];

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    modelAuto   = 1'b0;
    prevHeld    = 1'b0;
    lastAck     = 0;
    cyc         = 0;
    monErr      = 0;
    rst_n       = 1'b0;
    bus.app_req = 1'b0;
    bus.app_din = 32'hdac1_ffff;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_dsync", bus.DSYNC_N, {NUM_DEV{1'b1}});
    checkOutput("reset_dclk", bus.DCLK, 0);
    checkOutput("reset_din", bus.DIN, 0);
    checkOutput("reset_dldac", bus.DLDAC_N, 1);
    checkOutput("reset_ack", bus.app_ack, 0);
    checkOutput("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    clearMonitor();

    $display("[TB] directed: single device write");
    applyStimulus(32'hdac1_a5c3, 1'b0, 32'h0);
    $display("[TB] directed: auto-LDAC enable then device write");
    applyStimulus(32'hdace_0001, 1'b0, 32'h0);
    applyStimulus(32'hdac0_1234, 1'b0, 32'h0);
    $display("[TB] directed: broadcast with auto-LDAC");
    applyStimulus(32'hdad0_0ff0, 1'b0, 32'h0);
    $display("[TB] directed: unknown addresses and LDAC-only");
    applyStimulus(32'hdac5_0000, 1'b0, 32'h0);
    applyStimulus(32'h1234_0000, 1'b0, 32'h0);
    applyStimulus(32'hdacf_0000, 1'b0, 32'h0);
    $display("[TB] directed: request held across ack");
    applyStimulus(32'hdac0_beef, 1'b1, 32'hdac1_1357);
    applyStimulus(32'hdac1_1357, 1'b0, 32'h0);

    $display("[TB] directed: reset during bit 7");
    bus.app_din = 32'hdac1_ffff;
    bus.app_req = 1'b1;
    n = 0;
    while (!(inFrame && frPulses == 9 && bus.DCLK) && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("reach_bit7", n < BUDGET, 1);
    checkOutput("din_before_reset", bus.DIN, 1);
    rst_n = 1'b0;
    bus.app_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_dsync", bus.DSYNC_N, {NUM_DEV{1'b1}});
    checkOutput("midrst_dclk", bus.DCLK, 0);
    checkOutput("midrst_din", bus.DIN, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_dldac", bus.DLDAC_N, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    clearMonitor();
    modelAuto = 1'b0;
    prevHeld  = 1'b0;
    applyStimulus(32'hdac0_5a5a, 1'b0, 32'h0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      logic [15:0] dat;
      dat = 16'($urandom);
      case ($urandom_range(0, 6))
        0, 1:    words[t] = {ADDR_BASE + 16'($urandom_range(0, NUM_DEV - 1)), dat};
        2:       words[t] = {ADDR_ALL, dat};
        3:       words[t] = {ADDR_MODE, dat};
        4:       words[t] = {ADDR_LDAC, dat};
        5:       words[t] = {ADDR_BASE + 16'(NUM_DEV + $urandom_range(0, 5)), dat};
        default: words[t] = $urandom;
      endcase
    end
    for (int t = 0; t < 24; t++) begin
      bit hold;
      hold = (t < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(words[t], hold, (t < 23) ? words[t+1] : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_multi_ctrl.md
Name: dac_spi_multi_ctrl

Overview:
Parametrised multi-device serial DAC controller with an integrated SPI shifter, so no external SPI core is needed. Drives NUM_DEV SYNC lines, a shared DCLK/DIN and a shared LDAC. It decodes 32-bit register-bus writes: the high half is the address and the low half is data. Adds broadcast writes, an auto-LDAC mode and an error response for unknown addresses.

Parameters:
NUM_DEV, 2, number of DAC devices / DSYNC_N lines (1..8)
DATA_W, 16, SPI frame length in bits (8..16); frame = app_din[DATA_W-1:0], MSB first
CLK_DIV, 10, DCLK half-period in clk cycles (>=2)
LDAC_PULSE, 3, DLDAC_N low time in clk cycles (>=1)
ADDR_BASE, 16'hdac0, device n address = ADDR_BASE + n
ADDR_ALL, 16'hdad0, broadcast: same frame sent to every device in order 0..NUM_DEV-1
ADDR_MODE, 16'hdace, mode register write; app_din[0] = auto_ldac
ADDR_LDAC, 16'hdacf, LDAC pulse only, no SPI frame

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
DSYNC_N  out  NUM_DEV  per-device frame sync, active low
DCLK  out  1  SPI clock, CPOL=0 / CPHA=1
DIN  out  1  SPI data
DLDAC_N  out  1  DAC load strobe, active low
app_din  in  32  [31:16] address, [15:0] data
app_req  in  1  request, level, held until app_ack
app_ack  out  1  one-cycle completion pulse
app_err  out  1  valid with app_ack; 1 = unknown address
busy  out  1  high from accept until app_ack

Behaviour:
- Reset: synchronous, takes effect on the clk edge with rst_n=0, including mid-frame. Outputs go to DSYNC_N all 1, DCLK 0, DIN 0, DLDAC_N 1, app_ack 0, app_err 0, busy 0, auto_ldac 0. State returns to IDLE.
- States: IDLE, DECODE, LOAD, SHIFT, GAP, SYNCHI, LDAC, ACK.
- IDLE: accept when app_req=1 and app_ack=0. Latch app_din, set busy, go to DECODE.
- DECODE, one cycle:
  - Device address: dev_idx=n, go to LOAD.
  - ADDR_ALL: dev_idx=0, broadcast flag set, go to LOAD.
  - ADDR_MODE: update auto_ldac, go to ACK.
  - ADDR_LDAC: go to LDAC.
  - Anything else, including ADDR_BASE+n with n>=NUM_DEV: set err, go to ACK.
- LOAD: DSYNC_N[dev_idx]=0 for CLK_DIV cycles, DIN = frame MSB.
- SHIFT: DATA_W bits. Each bit has DCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - DIN changes only on DCLK rising edges: bit i is driven at the rise of bit i, and the MSB is driven from LOAD.
  - The device samples on the DCLK falling edge.
  - Bit counter is a down-counter with terminal count 0.
- GAP: DSYNC_N stays low, DCLK stays low, for CLK_DIV cycles.
- DSYNC_N[dev_idx] low time is exactly CLK_DIV*(2*DATA_W+2) cycles. Only one DSYNC_N is low at any time.
- SYNCHI: all DSYNC_N high for CLK_DIV cycles (minimum high time). Then:
  - If broadcast and dev_idx < NUM_DEV-1: dev_idx+1, go to LOAD.
  - Else if auto_ldac: go to LDAC.
  - Else: go to ACK.
- LDAC: DLDAC_N=0 for exactly LDAC_PULSE cycles, never while any DSYNC_N is low. Then go to ACK.
  - In broadcast with auto_ldac, only one pulse is issued, after the last device.
- ACK: app_ack=1 and app_err=err for one cycle, busy goes to 0 in the same cycle, return to IDLE.
  - The requester drops app_req after seeing app_ack.
  - app_req still high in the cycle after ack is treated as a new request.
- app_req and app_din are ignored while busy. The latched data is stable during the frame even if app_din changes.
- DCLK and DIN are registered, with no combinational path from app_* to the SPI pins.

Test Plan:
1. NUM_DEV=2, DATA_W=16, CLK_DIV=2; write 0xdac1_A5C3 -> DSYNC_N=2'b01 for exactly 68 cycles; 16 DCLK pulses, each 2 high / 2 low; DIN bits sampled at DCLK falls = 0xA5C3; DSYNC_N[0] stays 1; single app_ack with app_err=0; DLDAC_N stays 1.
2. Write 0xdace_0001, then 0xdac0_1234 -> after DSYNC_N[0] rises and 2 cycles of SYNCHI, DLDAC_N low for 3 cycles, then app_ack.
3. auto_ldac=1; write 0xdad0_0FF0 -> frames to dev0 then dev1, each carrying 0x0FF0, separated by >=2 cycles of all-high DSYNC_N; exactly one LDAC pulse after the second frame; one app_ack.
4. Write 0xdac5_0000 and 0x1234_0000 -> no DSYNC_N, DCLK or DLDAC_N activity; app_ack=1 with app_err=1 within 3 cycles of accept.
5. Assert rst_n=0 during bit 7 of a frame -> at the next edge DSYNC_N=all 1, DCLK=0, DIN=0, busy=0, auto_ldac=0; a following write completes normally.
6. Hold app_req high across ack with a new app_din, and toggle app_din mid-frame -> the mid-frame change does not alter the shifted data; the second request starts only after the ack cycle; back-to-back frames each see correct data.
